// File: rtl/sat_addsub_pkg.sv
// sat_addsub_pkg: op encodings and default sizes shared by the saturating add/sub pipe
package sat_addsub_pkg;
   typedef enum logic [1:0] {
      OP_ADD_SAT  = 2'b00,
      OP_SUB_SAT  = 2'b01,
      OP_PADD_SAT = 2'b10,
      OP_ADD_WRAP = 2'b11
   } op_t;
   localparam int DEF_WIDTH  = 16;
   localparam int DEF_LANE_W = 4;
endpackage

// File: rtl/sat_lane.sv
// sat_lane: W-bit carry-lookahead adder lane exposing carry into and out of its msb
module sat_lane #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         c_msb,
   output logic         cout
);
   logic [W-1:0] g, p;
   logic [W:0]   c;
   logic         acc, pp;
   assign g = a & b;
   assign p = a ^ b;
   // each carry is a flat OR of generate terms gated by the propagates above them
   always_comb begin
      c   = '0;
      acc = 1'b0;
      pp  = 1'b0;
      c[0] = cin;
      for (int i = 0; i < W; i++) begin
         acc = g[i];
         pp  = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc = acc | (pp & g[j]);
            pp  = pp & p[j];
         end
         c[i+1] = acc | (pp & cin);
      end
   end
   assign sum   = p ^ c[W-1:0];
   assign c_msb = c[W-1];
   assign cout  = c[W];
endmodule

// File: rtl/sat_addsub_pipe.sv
// sat_addsub_pipe: two-stage saturating add/sub with sub-word parallel add, flags and
// a sticky saturation counter, behind valid/ready handshakes with full back-pressure
module sat_addsub_pipe
   import sat_addsub_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int LANE_W = DEF_LANE_W,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic [1:0]               op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         sum,
   output logic [WIDTH/LANE_W-1:0]  ovf_lane,
   output logic                     flag_n,
   output logic                     flag_z,
   output logic                     flag_v,
   output logic [CNT_W-1:0]         sat_count,
   input  logic                     clr_count
);
   localparam int NL = WIDTH / LANE_W;
   localparam logic [LANE_W-1:0] L_MAX = {1'b0, {(LANE_W-1){1'b1}}};
   localparam logic [LANE_W-1:0] L_MIN = {1'b1, {(LANE_W-1){1'b0}}};
   localparam logic [WIDTH-1:0]  W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]  W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   op_t              op_in, s1_op_q, s2_op_q;
   logic             s1_valid_q, s2_valid_q, s1_en, s2_en;
   logic [WIDTH-1:0] b_eff, raw_d, s1_sum_q, padd_res, full_res, sum_d, sum_q;
   logic [NL-1:0]    lane_cin, cm_d, co_d, s1_cm_q, s1_co_q, ov, ovf_d, ovf_q;
   logic             full_v, fn_q, fz_q, fv_q, sat_ev;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   assign op_in    = op_t'(op);
   assign s2_en    = ~s2_valid_q | out_ready;
   assign s1_en    = ~s1_valid_q | s2_en;
   assign in_ready = s1_en;
   assign b_eff    = (op_in == OP_SUB_SAT) ? ~b : b;

   for (genvar i = 0; i < NL; i++) begin : g_lane
      if (i == 0) begin : g_lsb
         assign lane_cin[i] = (op_in == OP_SUB_SAT);
      end else begin : g_up
         assign lane_cin[i] = (op_in != OP_PADD_SAT) & co_d[i-1];
      end
      sat_lane #(.W(LANE_W)) u_lane (
         .a     (a[i*LANE_W +: LANE_W]),
         .b     (b_eff[i*LANE_W +: LANE_W]),
         .cin   (lane_cin[i]),
         .sum   (raw_d[i*LANE_W +: LANE_W]),
         .c_msb (cm_d[i]),
         .cout  (co_d[i])
      );
   end

   // a raw msb of 1 on overflow means the true result was positive
   assign ov       = s1_cm_q ^ s1_co_q;
   assign full_v   = ov[NL-1];
   assign full_res = full_v ? (s1_sum_q[WIDTH-1] ? W_MAX : W_MIN) : s1_sum_q;
   always_comb begin
      padd_res = s1_sum_q;
      for (int l = 0; l < NL; l++)
         if (ov[l]) padd_res[l*LANE_W +: LANE_W] = s1_sum_q[l*LANE_W+LANE_W-1] ? L_MAX : L_MIN;
   end
   assign sum_d = (s1_op_q == OP_PADD_SAT) ? padd_res :
                  (s1_op_q == OP_ADD_WRAP) ? s1_sum_q : full_res;
   assign ovf_d = (s1_op_q == OP_PADD_SAT) ? ov : {NL{full_v}};

   assign sat_ev = s2_valid_q & out_ready & fv_q & (s2_op_q != OP_ADD_WRAP);
   assign cnt_d  = clr_count ? '0 : (sat_ev & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s1_cm_q    <= '0;
         s1_co_q    <= '0;
         s1_op_q    <= OP_ADD_SAT;
         s2_op_q    <= OP_ADD_SAT;
         sum_q      <= '0;
         ovf_q      <= '0;
         fn_q       <= 1'b0;
         fz_q       <= 1'b0;
         fv_q       <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (s1_en) s1_valid_q <= in_valid;
         if (s1_en & in_valid) begin
            s1_sum_q <= raw_d;
            s1_cm_q  <= cm_d;
            s1_co_q  <= co_d;
            s1_op_q  <= op_in;
         end
         if (s2_en) s2_valid_q <= s1_valid_q;
         if (s2_en & s1_valid_q) begin
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            fn_q    <= sum_d[WIDTH-1];
            fz_q    <= (sum_d == '0);
            fv_q    <= |ovf_d;
            s2_op_q <= s1_op_q;
         end
         cnt_q <= cnt_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign sum       = sum_q;
   assign ovf_lane  = ovf_q;
   assign flag_n    = fn_q;
   assign flag_z    = fz_q;
   assign flag_v    = fv_q;
   assign sat_count = cnt_q;
endmodule

// File: tb/tb_sat_addsub_pipe.sv
// tb_sat_addsub_pipe: directed and randomized checks against an integer-arithmetic reference model
module tb_sat_addsub_pipe;
   localparam int W = 16, L = 4, NL = 4;

   logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_count = 1'b0;
   logic [W-1:0]  a = '0, b = '0;
   logic [1:0]    op = 2'd0;
   logic          in_ready, out_valid, flag_n, flag_z, flag_v;
   logic [W-1:0]  sum;
   logic [NL-1:0] ovf_lane;
   logic [7:0]    sat_count;
   logic          in_ready2, out_valid2, flag_n2, flag_z2, flag_v2;
   logic [W-1:0]  sum2;
   logic [NL-1:0] ovf_lane2;
   logic [1:0]    sat_count2;

   typedef struct packed {logic [W-1:0] s; logic [NL-1:0] ovf; logic [1:0] op;} exp_t;
   exp_t q[$];
   exp_t expv, got;
   logic acc, ofire, have_exp, gn, gz, gv;
   int   mcnt = 0, mcnt2 = 0, tests = 0, fails = 0;

   sat_addsub_pipe #(.WIDTH(W), .LANE_W(L), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf_lane(ovf_lane), .flag_n(flag_n),
      .flag_z(flag_z), .flag_v(flag_v), .sat_count(sat_count), .clr_count(clr_count));
   sat_addsub_pipe #(.WIDTH(W), .LANE_W(L), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b), .op(op),
      .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .ovf_lane(ovf_lane2), .flag_n(flag_n2),
      .flag_z(flag_z2), .flag_v(flag_v2), .sat_count(sat_count2), .clr_count(clr_count));

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      int   r, xa, yb;
      logic v;
      e.op = o; e.ovf = '0; e.s = '0;
      if (o == 2'd2) begin
         for (int i = 0; i < NL; i++) begin
            xa = int'($signed(x[i*L +: L]));
            yb = int'($signed(y[i*L +: L]));
            r  = xa + yb;
            if (r > 7) begin r = 7; e.ovf[i] = 1'b1; end
            else if (r < -8) begin r = -8; e.ovf[i] = 1'b1; end
            e.s[i*L +: L] = r[L-1:0];
         end
      end else begin
         xa = int'($signed(x));
         yb = int'($signed(y));
         r  = (o == 2'd1) ? xa - yb : xa + yb;
         v  = (r > 32767) || (r < -32768);
         e.ovf = {NL{v}};
         e.s = (v && o != 2'd3) ? ((r > 0) ? 16'h7FFF : 16'h8000) : r[W-1:0];
      end
      return e;
   endfunction

   // one clock of stimulus: entered just after a falling edge, returns at the next one
   task automatic cycle(input logic v, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ordy, input logic clr);
      logic sat;
      in_valid = v; op = o; a = x; b = y; out_ready = ordy; clr_count = clr;
      #1;
      acc   = v & in_ready;
      ofire = out_valid & ordy;
      got.s = sum; got.ovf = ovf_lane; got.op = 2'd0;
      gn = flag_n; gz = flag_z; gv = flag_v;
      have_exp = 1'b0;
      if (ofire && q.size() > 0) begin expv = q.pop_front(); have_exp = 1'b1; end
      if (acc) q.push_back(model(o, x, y));
      sat   = have_exp && (|expv.ovf) && expv.op != 2'd3;
      mcnt  = clr ? 0 : (sat && mcnt < 255) ? mcnt + 1 : mcnt;
      mcnt2 = clr ? 0 : (sat && mcnt2 < 3) ? mcnt2 + 1 : mcnt2;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if (out_valid !== 1'b0 || sat_count !== 8'd0 || sum !== '0 || ovf_lane !== '0 ||
          {flag_n, flag_z, flag_v} !== 3'b000 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset: got valid=%b cnt=%h sum=%h ovf=%h nzv=%b%b%b rdy=%b expected 0/0/0/0/000/1",
                  out_valid, sat_count, sum, ovf_lane, flag_n, flag_z, flag_v, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [1:0]    vo[6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
      logic [W-1:0]  va[6] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0005, 16'h781F, 16'h7FFF};
      logic [W-1:0]  vb[6] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h0005, 16'h1F11, 16'h0001};
      logic [W-1:0]  vs[6] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h7820, 16'h8000};
      logic [NL-1:0] vv[6] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hC, 4'hF};
      logic [7:0]    vc[6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4};
      int n;
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, vo[k], va[k], vb[k], 1'b1, 1'b0);
         n = 0;
         do begin cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0); n++; end while (!ofire && n < 8);
         tests++;
         if (!ofire || n != 2) begin
            fails++;
            $display("FAIL directed%0d latency: got %0d cycles expected 2", k, n);
         end
         tests++;
         if (got.s !== vs[k] || got.ovf !== vv[k] || gn !== vs[k][W-1] || gz !== (vs[k] == '0) || gv !== (|vv[k])) begin
            fails++;
            $display("FAIL directed%0d result: got sum=%h ovf=%h nzv=%b%b%b expected sum=%h ovf=%h",
                     k, got.s, got.ovf, gn, gz, gv, vs[k], vv[k]);
         end
         tests++;
         if (sat_count !== vc[k]) begin
            fails++;
            $display("FAIL directed%0d count: got %0d expected %0d", k, sat_count, vc[k]);
         end
      end
   endtask

   task automatic test_random();
      logic clr;
      for (int k = 0; k < 400; k++) begin
         clr = ($urandom_range(0, 19) == 0);
         cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
               $urandom_range(0, 9) < 7, clr);
         if (ofire) begin
            tests++;
            if (!have_exp || got.s !== expv.s || got.ovf !== expv.ovf || gn !== expv.s[W-1] ||
                gz !== (expv.s == '0) || gv !== (|expv.ovf)) begin
               fails++;
               $display("FAIL random%0d result: got sum=%h ovf=%h nzv=%b%b%b expected sum=%h ovf=%h (have=%b)",
                        k, got.s, got.ovf, gn, gz, gv, expv.s, expv.ovf, have_exp);
            end
         end
         tests++;
         if (sat_count !== 8'(mcnt) || sat_count2 !== 2'(mcnt2)) begin
            fails++;
            $display("FAIL random%0d count: got %0d/%0d expected %0d/%0d", k, sat_count, sat_count2, mcnt, mcnt2);
         end
      end
      for (int k = 0; k < 8 && q.size() > 0; k++) cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
      tests++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL random drain: got %0d pending valid=%b expected 0 pending", q.size(), out_valid);
      end
   endtask

   task automatic test_back_pressure();
      logic [W-1:0] ba[4] = '{16'h0123, 16'h1000, 16'h7000, 16'h8001};
      logic [W-1:0] held;
      int idx = 0;
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, 2'd0, ba[idx], 16'h0111, 1'b0, 1'b0);
         if (acc) idx++;
         if (k == 2) held = got.s;
      end
      tests++;
      if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL bp accept: got %0d accepted rdy=%b valid=%b expected 2/0/1", idx, in_ready, out_valid);
      end
      tests++;
      if (got.s !== held) begin
         fails++;
         $display("FAIL bp stable: got %h expected %h", got.s, held);
      end
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
         tests++;
         if (!ofire || !have_exp || got.s !== expv.s || got.s !== ba[k] + 16'h0111) begin
            fails++;
            $display("FAIL bp drain%0d: got fire=%b sum=%h expected fire=1 sum=%h", k, ofire, got.s, ba[k] + 16'h0111);
         end
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp empty: got valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_counter_sat();
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) cycle(1'b1, 2'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
      tests++;
      if (sat_count2 !== 2'd3 || sat_count !== 8'd5) begin
         fails++;
         $display("FAIL count_sat: got %0d/%0d expected 3/5", sat_count2, sat_count);
      end
   endtask

   task automatic test_clr_priority();
      cycle(1'b1, 2'd1, 16'h8000, 16'h0001, 1'b1, 1'b0);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b1);
      tests++;
      if (!ofire || gv !== 1'b1 || sat_count !== 8'd0 || sat_count2 !== 2'd0) begin
         fails++;
         $display("FAIL clr_priority: got fire=%b v=%b cnt=%0d/%0d expected 1/1/0/0", ofire, gv, sat_count, sat_count2);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      cycle(1'b1, 2'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b0);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
      cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
      cycle(1'b1, 2'd0, 16'h0001, 16'h0002, 1'b0, 1'b0);
      cycle(1'b1, 2'd0, 16'h0003, 16'h0004, 1'b0, 1'b0);
      cycle(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
      tests++;
      if (sat_count !== 8'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid pre: got cnt=%0d valid=%b rdy=%b expected 1/1/0", sat_count, out_valid, in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || sat_count !== 8'd0 || sum !== '0) begin
         fails++;
         $display("FAIL reset_mid flush: got valid=%b cnt=%0d sum=%h expected 0/0/0", out_valid, sat_count, sum);
      end
      q.delete(); mcnt = 0; mcnt2 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 2'd3, 16'h1234, 16'h1111, 1'b1, 1'b0);
      n = 0;
      do begin cycle(1'b0, 2'd0, '0, '0, 1'b1, 1'b0); n++; end while (!ofire && n < 8);
      tests++;
      if (!ofire || n != 2 || got.s !== 16'h2345) begin
         fails++;
         $display("FAIL reset_mid first: got fire=%b after %0d sum=%h expected 2 cycles sum=2345", ofire, n, got.s);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_pressure();
      test_counter_sat();
      test_clr_priority();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
